// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART frame transmitter (start, DATA_BITS LSB first, optional even parity, stop).
// Define UART_TX_PARITY_EN to insert the even-parity bit between data and stop.
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_start,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 serial_out
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP  = 3'd4;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
   logic parity;
`endif
   logic [2:0]           state;
   logic [TW-1:0]        timer;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 tc;
   assign tc      = timer == TW'(CLKS_PER_BIT - 1);
   assign tx_busy = state != IDLE;
   assign tx_done = (state == STOP) && tc;
   // serial_out is loaded with the value of the bit being entered, so the line is glitch-free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         timer      <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         serial_out <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity     <= 1'b0;
`endif
      end else if (state == IDLE) begin
         if (tx_start) begin
            state      <= START;
            shift_reg  <= tx_data;
            timer      <= '0;
            serial_out <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity     <= ^tx_data;
`endif
         end
      end else if (!tc) begin
         timer <= timer + 1'b1;
      end else begin
         timer <= '0;
         case (state)
            START: begin
               state      <= DATA;
               bit_idx    <= '0;
               serial_out <= shift_reg[0];
            end
            DATA: begin
               if (bit_idx == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state      <= PARITY;
                  serial_out <= parity;
`else
                  state      <= STOP;
                  serial_out <= 1'b1;
`endif
               end else begin
                  bit_idx    <= bit_idx + 1'b1;
                  shift_reg  <= shift_reg >> 1;
                  serial_out <= shift_reg[1];
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               state      <= STOP;
               serial_out <= 1'b1;
            end
`endif
            default: begin
               state      <= IDLE;
               serial_out <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: randomized and directed checks against a frame-level model of the UART transmitter.
module tb_uart_tx_serializer;
   localparam int CPB = 10;
   localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
   localparam int NB = DB + 3;
   localparam logic [15:0] A5_SEQ = 16'b10101001010;
   localparam logic [15:0] X5A_SEQ = 16'b10010110100;
`else
   localparam int NB = DB + 2;
   localparam logic [15:0] A5_SEQ = 16'b1101001010;
   localparam logic [15:0] X5A_SEQ = 16'b1010110100;
`endif
   localparam int FLEN = NB * CPB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DB-1:0] tx_data = '0;
   logic          tx_start = 1'b0;
   logic          tx_busy, tx_done, serial_out;
   int            checks = 0;
   int            errors = 0;
   int            m_k = 0;
   logic [DB-1:0] m_word = '0;
   logic [15:0]   seq;

   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy), .tx_done(tx_done), .serial_out(serial_out));

   always #5 clk = ~clk;

   function automatic logic frame_bit(input logic [DB-1:0] w, input int j);
      if (j == 0) return 1'b0;
      if (j <= DB) return w[j-1];
      if (j == DB + 1 && NB == DB + 3) return ^w;
      return 1'b1;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // m_k is the 1-based clock index within the current frame, 0 when idle
   always @(posedge clk or posedge rst) begin
      if (rst) m_k = 0;
      else if (m_k == 0) begin
         if (tx_start) begin
            m_k = 1;
            m_word = tx_data;
         end
      end else m_k = (m_k == FLEN) ? 0 : m_k + 1;
   end

   always @(negedge clk) begin
      chk("model serial_out", {31'd0, serial_out}, {31'd0, (m_k == 0) ? 1'b1 : frame_bit(m_word, (m_k - 1) / CPB)});
      chk("model tx_busy", {31'd0, tx_busy}, {31'd0, m_k != 0});
      chk("model tx_done", {31'd0, tx_done}, {31'd0, m_k == FLEN});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DB-1:0] d);
      tx_data = d;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
   endtask

   task automatic wait_done(input int n0, output int n);
      n = n0;
      seq = '0;
      forever begin
         if ((n - 1) % CPB == CPB / 2 && (n - 1) / CPB < 16) seq[(n - 1) / CPB] = serial_out;
         if (tx_done || n >= 3 * FLEN) break;
         tick();
         n++;
      end
      if (!tx_done) chk("tx_done timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int n;
      repeat (3) tick();
      rst = 1'b0;
      chk("reset serial_out", {31'd0, serial_out}, 32'd1);
      chk("reset tx_busy", {31'd0, tx_busy}, 32'd0);
      chk("reset tx_done", {31'd0, tx_done}, 32'd0);
      repeat (50) tick();
      chk("idle line", {31'd0, serial_out}, 32'd1);

      send(8'hA5);
      chk("A5 busy after accept", {31'd0, tx_busy}, 32'd1);
      chk("A5 start bit", {31'd0, serial_out}, 32'd0);
      wait_done(1, n);
      chk("A5 frame length", n, FLEN);
      chk("A5 bit sequence", {16'd0, seq}, {16'd0, A5_SEQ});

      tick();
      tx_data = 8'h00;
      tx_start = 1'b1;
      tick();
      tx_data = 8'hFF;
      wait_done(1, n);
      chk("b2b first length", n, FLEN);
      tick();
      chk("b2b gap busy", {31'd0, tx_busy}, 32'd0);
      chk("b2b gap line", {31'd0, serial_out}, 32'd1);
      tick();
      tx_start = 1'b0;
      chk("b2b second busy", {31'd0, tx_busy}, 32'd1);
      wait_done(1, n);
      chk("b2b second length", n, FLEN);
      chk("b2b FF data bits", {16'd0, seq[DB:1]}, 32'hFF);

      tick();
      send(8'h3C);
      repeat (39) tick();
      tx_data = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         tx_start = ~tx_start;
         tick();
      end
      tx_start = 1'b0;
      wait_done(44, n);
      repeat (3) tick();
      chk("no second frame", {31'd0, tx_busy}, 32'd0);

      send(8'h5A);
      repeat (54) tick();
      #1 rst = 1'b1;
      #1;
      chk("async rst line", {31'd0, serial_out}, 32'd1);
      chk("async rst busy", {31'd0, tx_busy}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      send(8'h5A);
      wait_done(1, n);
      chk("5A frame length", n, FLEN);
      chk("5A bit sequence", {16'd0, seq}, {16'd0, X5A_SEQ});

      for (int r = 0; r < 25; r++) begin
         int gap, tog;
         gap = $urandom_range(1, 4);
         repeat (gap) tick();
         send(DB'($urandom));
         tog = $urandom_range(0, 15);
         for (int i = 0; i < tog; i++) begin
            tx_start = 1'($urandom);
            tx_data = DB'($urandom);
            tick();
         end
         tx_start = 1'b0;
         wait_done(tog + 1, n);
         chk("random frame length", n, FLEN);
      end
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
